// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operation is processed one
//   DIGIT-bit slice per clock, LSB slice first, with the inter-slice carry
//   held in a register. One operation in flight at a time.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active low
//   START  : request an operation (sampled only while BUSY=0)
//   SUB    : 0 -> S = A + B + CIN, 1 -> S = A - B (CIN ignored)
//   A, B   : operands, captured on the accepting edge
//   CIN    : carry-in for add mode, captured on the accepting edge
//   BUSY   : operation in progress
//   DONE   : one-cycle pulse, S/COUT/OVF just updated
//   S      : result register (holds last completed result)
//   COUT   : carry out of the MSB (subtract: 1 = no borrow)
//   OVF    : two's-complement signed overflow of the completed operation
//
// States
//   IDLE | waiting for START; result registers hold last completion
//   RUN  | one slice added per clock, NDIG clocks total

module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int LAST = NDIG - 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Slice adder: one extra bit on top carries into the next slice.
  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] acc_next;
  logic             last_slice;

  always_comb begin
    slice_sum = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};
    // New slice enters at the top; after NDIG shifts the LSB slice has
    // walked down to bit 0 and the register holds the full result.
    acc_next   = (acc_q >> DIGIT)
               | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last_slice = (cnt_q == CW'(LAST));
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          opa_d   = A;
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          opb_d   = SUB ? ~B : B;
          carry_d = SUB ? 1'b1 : CIN;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        acc_d   = acc_next;
        carry_d = slice_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          s_d     = acc_next;
          cout_d  = slice_sum[DIGIT];
          // Operand MSBs sit at the top of the final slice; opb is already
          // inverted in subtract mode so one rule covers both modes.
          ovf_d   = (opa_q[DIGIT-1] == opb_q[DIGIT-1])
                 && (slice_sum[DIGIT-1] != opa_q[DIGIT-1]);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = (state_q == RUN);
  assign DONE = done_q;
  assign S    = s_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
module tb_digit_serial_adder;

  logic clk;
  logic rst_n;

  // 32-bit / 4-bit-digit instance
  logic        st32, sub32, cin32;
  logic [31:0] a32, b32;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] s32;

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .START(st32), .SUB(sub32), .A(a32), .B(b32),
    .CIN(cin32), .BUSY(busy32), .DONE(done32), .S(s32), .COUT(cout32), .OVF(ovf32)
  );

  // 8-bit instances: DIGIT = 8, 4, 1
  logic       st8 [3];
  logic       sub8 [3];
  logic       cin8 [3];
  logic [7:0] a8 [3];
  logic [7:0] b8 [3];
  logic       busy8 [3];
  logic       done8 [3];
  logic       cout8 [3];
  logic       ovf8 [3];
  logic [7:0] s8 [3];

  for (genvar g = 0; g < 3; g++) begin : g_w8
    digit_serial_adder #(.WIDTH(8), .DIGIT(g == 0 ? 8 : (g == 1 ? 4 : 1))) dut8 (
      .clk(clk), .rst_n(rst_n), .START(st8[g]), .SUB(sub8[g]), .A(a8[g]), .B(b8[g]),
      .CIN(cin8[g]), .BUSY(busy8[g]), .DONE(done8[g]), .S(s8[g]), .COUT(cout8[g]),
      .OVF(ovf8[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input logic cin, input logic sub,
                                output longint s, output logic cout, output logic ovf);
    longint lim, half, sa, sb, u, r;
    lim  = longint'(1) << w;
    half = lim / 2;
    if (sub) begin
      u    = ua - ub;
      cout = (ua >= ub);
      r    = 0;
    end else begin
      u    = ua + ub + longint'(cin);
      cout = (u >= lim);
    end
    s  = u & (lim - 1);
    sa = (ua >= half) ? ua - lim : ua;
    sb = (ub >= half) ? ub - lim : ub;
    r  = sub ? (sa - sb) : (sa + sb + longint'(cin));
    ovf = (r >= half) || (r < -half);
  endfunction

  // Issue one 32-bit op starting at a negedge; returns at the DONE negedge.
  // With spam set, START is re-raised mid-run with unrelated operands.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input bit spam, input logic [31:0] es,
                      input logic ec, input logic eo, input string nm);
    logic [31:0] sprev;
    bit          stable;
    int          lat;
    sprev  = s32;
    stable = 1'b1;
    a32 = a; b32 = b; cin32 = cin; sub32 = sub; st32 = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) chk({nm, "_busy"}, 64'(busy32), 64'(1));
      st32 = spam && (i >= 2) && (i <= 5);
      if (spam) begin
        a32 = ~a; b32 = a; cin32 = ~cin; sub32 = ~sub;
      end
      if (done32) begin
        lat = i;
        break;
      end
      if (s32 !== sprev) stable = 1'b0;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(9));
    chk({nm, "_s"}, 64'(s32), 64'(es));
    chk({nm, "_cout"}, 64'(cout32), 64'(ec));
    chk({nm, "_ovf"}, 64'(ovf32), 64'(eo));
    chk({nm, "_hold"}, 64'(stable), 64'(1));
  endtask

  task automatic op8(input int k, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic sub);
    longint es;
    logic   ec, eo;
    int     lat, nd;
    nd = (k == 0) ? 1 : ((k == 1) ? 2 : 8);
    model(8, longint'(a), longint'(b), cin, sub, es, ec, eo);
    a8[k] = a; b8[k] = b; cin8[k] = cin; sub8[k] = sub; st8[k] = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        st8[k]  = 1'b0;
        a8[k]   = 8'($urandom);
        b8[k]   = 8'($urandom);
        cin8[k] = 1'($urandom);
        sub8[k] = 1'($urandom);
      end
      if (done8[k]) begin
        lat = i;
        break;
      end
    end
    chk($sformatf("sw%0d_lat", k), 64'(lat), 64'(nd + 1));
    chk($sformatf("sw%0d_s", k), 64'(s8[k]), 64'(es));
    chk($sformatf("sw%0d_cout", k), 64'(cout8[k]), 64'(ec));
    chk($sformatf("sw%0d_ovf", k), 64'(ovf8[k]), 64'(eo));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;

    tbl[0] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2] = '{32'h0000000F, 32'h00000000, 1'b1, 1'b0, 32'h00000010, 1'b0, 1'b0};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[5] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[8] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    tbl[9] = '{32'h00000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};

    rst_n = 1'b0;
    st32 = 1'b0; sub32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0;
    for (int k = 0; k < 3; k++) begin
      st8[k] = 1'b0; sub8[k] = 1'b0; cin8[k] = 1'b0; a8[k] = '0; b8[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy32), 64'(0));
    chk("rst_done", 64'(done32), 64'(0));
    chk("rst_s", 64'(s32), 64'(0));
    chk("rst_cout", 64'(cout32), 64'(0));
    chk("rst_ovf", 64'(ovf32), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Table ops issued back to back: each START lands in the previous DONE cycle.
    for (int i = 0; i < 10; i++)
      op32(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b0,
           tbl[i].s, tbl[i].cout, tbl[i].ovf, $sformatf("tbl%0d", i));

    op32(32'h00000100, 32'h00000200, 1'b0, 1'b0, 1'b1,
         32'h00000300, 1'b0, 1'b0, "ignore_start");
    chk("pulse_len", 64'(done32), 64'(1));
    @(negedge clk);
    chk("pulse_end", 64'(done32), 64'(0));

    // Leave a nonzero result and OVF in place, then abort mid-run.
    op32(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0,
         32'hFFFFFFFE, 1'b0, 1'b1, "pre_abort");
    a32 = 32'hAAAAAAAA; b32 = 32'h55555555; cin32 = 1'b1; sub32 = 1'b0; st32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st32 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy32), 64'(0));
    chk("abort_s", 64'(s32), 64'(0));
    chk("abort_cout", 64'(cout32), 64'(0));
    chk("abort_ovf", 64'(ovf32), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done32 || busy32) seen_done = 1'b1;
    end
    chk("abort_no_done", 64'(seen_done), 64'(0));
    op32(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0,
         32'h23456789, 1'b0, 1'b0, "post_abort");

    // Parameter sweep against the arithmetic model.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int n = 0; n < 1000; n++)
        op8(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operation one DIGIT-bit slice per clock, LSB slice first, and carries between slices in a register.
- Successor to the fixed-width 4/8-bit ripple adders. Trades latency for area on wide datapaths (32/64-bit).
- Adds subtract mode, signed-overflow detection and a start/busy/done handshake.
- Sits between a register file and a controller that issues one operation at a time.

Parameters:
WIDTH, 32, operand and result width in bits.
DIGIT, 4, bits processed per cycle. Must divide WIDTH exactly; other values are unsupported and must fail an elaboration-time check.
NDIG, WIDTH/DIGIT, derived local parameter, not overridable. Number of slices, which is also the latency in cycles.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  asynchronous reset, active-low.
START  in  1  request a new operation; sampled only while BUSY=0.
SUB  in  1  0: S=A+B+CIN; 1: S=A-B (computed as A+~B+1; CIN ignored).
A  in  WIDTH  operand A, captured on the accepting edge.
B  in  WIDTH  operand B, captured on the accepting edge.
CIN  in  1  carry-in for add mode, captured on the accepting edge.
BUSY  out  1  high while an operation is in progress.
DONE  out  1  one-cycle pulse marking S/COUT/OVF updated.
S  out  WIDTH  result register.
COUT  out  1  carry out of the MSB. In subtract mode, 1 = no borrow.
OVF  out  1  two's-complement signed overflow of the completed operation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; BUSY=0, DONE=0, S=0, COUT=0, OVF=0.
  - Internal operand shift registers, carry register and slice counter all cleared.
- IDLE, START=1 at edge t0:
  - Capture A into opA and (SUB ? ~B : B) into opB.
  - Carry register <= SUB ? 1 : CIN.
  - Counter <= 0; go to RUN; BUSY=1 from t0.
- RUN, each edge:
  - Add opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Shift the DIGIT-bit sum into the top of the internal result shift register.
  - Shift opA and opB right by DIGIT; carry <= slice carry-out; counter++.
- Final slice (counter==NDIG-1), at edge t0+NDIG:
  - S <= full internal result; COUT <= slice carry-out.
  - OVF <= (opA_msb == opB_msb) && (sum_msb != opA_msb), using the MSB bits of the final slice; opB_msb is after inversion in SUB mode.
  - BUSY <= 0; DONE <= 1 for exactly one cycle; state -> IDLE.
- Latency: DONE high in the cycle following edge t0+NDIG, i.e. NDIG cycles after the accepting edge. Throughput is one operation per NDIG cycles.
- S, COUT and OVF hold the last completed result until the next completion. They do not change during RUN.
- START while BUSY=1 is ignored. A, B, CIN and SUB may change freely during RUN with no effect.
- START in the DONE cycle: BUSY is already 0, so the request is accepted. Back-to-back operations are allowed with no idle gap.
- DIGIT==WIDTH (NDIG=1): single RUN cycle; DONE one cycle after START.
- Reset mid-operation: the operation is aborted; all outputs return to reset values; no DONE is issued.
- No X propagation: the counter width is clog2(NDIG), minimum 1 bit.

Test Plan:
1. WIDTH=32, DIGIT=4: A=0x00000001, B=0xFFFFFFFF, CIN=0, SUB=0, START pulse -> BUSY high for 8 cycles; DONE 8 cycles after accept; S=0x00000000, COUT=1, OVF=0.
2. Signed overflow, add mode: A=0x7FFFFFFF, B=0x00000001, CIN=0, SUB=0 -> S=0x80000000, COUT=0, OVF=1. Also A=0x0000000F, B=0x00000000, CIN=1 -> S=0x00000010, COUT=0, OVF=0.
3. Subtract mode:
   - A=5, B=7, SUB=1, CIN=1 (ignored) -> S=0xFFFFFFFE, COUT=0, OVF=0.
   - A=0x80000000, B=1, SUB=1 -> S=0x7FFFFFFF, COUT=1, OVF=1.
4. Handshake:
   - START re-asserted at cycles 2-5 of RUN with different operands -> ignored; result matches the first operands.
   - START held in the DONE cycle -> second operation accepted; its DONE arrives exactly 8 cycles later.
   - S stable between completions.
5. Reset abort: drop rst_n at cycle 4 of RUN -> immediately BUSY=0, S=0, COUT=0, OVF=0; no DONE pulse. After release, A=0x12345678 + B=0x11111111 -> S=0x23456789.
6. Parameter sweep: WIDTH=8 with DIGIT=8, 4 and 1 (latency 1, 2 and 8). Run 1000 random A/B/CIN/SUB operations each against a behavioural model; S, COUT, OVF and DONE timing must match.
